mips_multicycle_fsm: RTL and testbench

//  Multi-cycle MIPS main controller. Sequences the shared datapath (one memory, one ALU, IR/A/B/ALUOut regs)

---
 rtl/mips_multicycle_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_mips_multicycle_fsm.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_fsm.sv
// rtl/mips_multicycle_fsm.sv - multi-cycle MIPS main controller FSM
//
// Purpose: sequences the shared multi-cycle datapath (one memory, one ALU,
// IR/A/B/ALUOut registers) through fetch/decode/execute/memory/write-back
// steps for R-type, LW, SW, BEQ, J and ORI. Stalls on a memory ready
// handshake and counts retired instructions.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an unknown opcode traps in ILLEGAL (sticky illegal_op) until rst
//   undefined : an unknown opcode retires as a one-cycle NOP
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   opcode[5:0]        IR[31:26], looked at only in DECODE and MEMADR
//   mem_ready          memory finishes the current access this cycle
//   PCWrite            unconditional PC load
//   PCWriteCond        PC load when ALU zero (BEQ)
//   IorD               memory address: 0 PC, 1 ALUOut
//   MemRead, MemWrite  memory requests
//   MemtoReg           register write data: 0 ALUOut, 1 MDR
//   IRWrite            instruction register load
//   PCSource[1:0]      00 ALU, 01 ALUOut, 10 jump target
//   ALUOp[1:0]         00 add, 01 sub, 10 funct, 11 or
//   ALUSrcA            0 PC, 1 A
//   ALUSrcB[1:0]       00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   RegWrite, RegDst   register file write enable, destination 0 rt / 1 rd
//   instr_count        retired-instruction counter (wraps)
//   illegal_op         sticky illegal-opcode flag (trap build only)

module mips_multicycle_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_ORI = 6'd13;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_RWB, S_BRANCH, S_JUMP, S_ORIEX, S_ORIWB, S_ILLEGAL
  } state_t;

  state_t state, state_next;
  logic   retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Set on entry so the flag is already visible in the first ILLEGAL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (state_next == S_ILLEGAL)
      illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC+4 are only committed on the cycle the read completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)
          state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_R:          state_next = S_EXEC;
          OP_LW, OP_SW:  state_next = S_MEMADR;
          OP_BEQ:        state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          OP_ORI:        state_next = S_ORIEX;
          default:       state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_LW)
          state_next = S_MEMRD;
        else if (opcode == OP_SW)
          state_next = S_MEMWR;
        else
          state_next = S_ILLEGAL;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)
          state_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        state_next = S_RWB;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ORIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = 2'b11;
        state_next = S_ORIWB;
      end
      S_ORIWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        state_next = S_ILLEGAL;
`else
        retire     = 1'b1;
        state_next = S_FETCH;
`endif
      end
      default: state_next = S_FETCH;
    endcase

    // While reset is held the state register already reads FETCH, so the
    // datapath controls must be blanked explicitly.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// tb/tb_mips_multicycle_fsm.sv - self-checking bench for mips_multicycle_fsm

module tb_mips_multicycle_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [31:0] instr_count;

  logic rst4 = 1'b1;
  logic [5:0] opcode4 = 6'd2;
  logic mem_ready4 = 1'b1;
  logic pcw4, pcwc4, iord4, mr4, mw4, m2r4, irw4, srca4, rw4, rd4, ill4;
  logic [1:0] pcs4, aluop4, srcb4;
  logic [3:0] instr_count4;

  always #5 clk = ~clk;

  mips_multicycle_fsm #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .instr_count(instr_count), .illegal_op(illegal_op)
  );

  mips_multicycle_fsm #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst4), .opcode(opcode4), .mem_ready(mem_ready4),
    .PCWrite(pcw4), .PCWriteCond(pcwc4), .IorD(iord4), .MemRead(mr4),
    .MemWrite(mw4), .MemtoReg(m2r4), .IRWrite(irw4), .PCSource(pcs4),
    .ALUOp(aluop4), .ALUSrcA(srca4), .ALUSrcB(srcb4), .RegWrite(rw4),
    .RegDst(rd4), .instr_count(instr_count4), .illegal_op(ill4)
  );

  logic [15:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};

  function automatic logic [15:0] mk(input logic pcw, pcwc, iord, mr, mw, m2r, irw,
                                     input logic [1:0] pcs, aluop, input logic srca,
                                     input logic [1:0] srcb, input logic rw, rd);
    return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aluop, srca, srcb, rw, rd};
  endfunction

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic mr, input logic [5:0] op);
    @(negedge clk);
    mem_ready = mr;
    opcode = op;
    #1;
  endtask

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      6'd0:    return 4;
      6'd35:   return 5;
      6'd43:   return 4;
      6'd4:    return 3;
      6'd2:    return 3;
      6'd13:   return 4;
      default: return 3;
    endcase
  endfunction

  typedef struct {
    logic        mr;
    logic [5:0]  op;
    logic [15:0] exp;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic mr, input logic [5:0] op, input logic [15:0] exp,
                     input logic [31:0] cnt);
    tbl.push_back('{mr, op, exp, cnt});
  endtask

  logic [15:0] E_FR, E_FW, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR, E_EXEC, E_RWB;
  logic [15:0] E_BR, E_JMP, E_OEX, E_OWB;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lw_mr [10];
    logic [5:0] ops [7];
    int nops, irw, ninstr, budget, cyc, waits, rw, pcw;
    logic seen, r;
    logic [5:0] cur_op;
    logic [31:0] exp_cnt;

    E_FR   = mk(1,0,0,1,0,0,1,2'b00,2'b00,0,2'b01,0,0);
    E_FW   = mk(0,0,0,1,0,0,0,2'b00,2'b00,0,2'b01,0,0);
    E_DEC  = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0);
    E_MADR = mk(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0);
    E_MRD  = mk(0,0,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,0);
    E_MWB  = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,2'b00,1,0);
    E_MWR  = mk(0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0);
    E_EXEC = mk(0,0,0,0,0,0,0,2'b00,2'b10,1,2'b00,0,0);
    E_RWB  = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,1);
    E_BR   = mk(0,1,0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0);
    E_JMP  = mk(1,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,0,0);
    E_OEX  = mk(0,0,0,0,0,0,0,2'b00,2'b11,1,2'b10,0,0);
    E_OWB  = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0);

    // Outputs blanked while reset is held, even with mem_ready high.
    apply(0, 6'd0);
    apply(1, 6'd0);
    check("reset_ctl", ctl, 0);
    check("reset_cnt", instr_count, 0);
    check("reset_illegal", illegal_op, 0);

    // CNT_W=4 instance retiring back-to-back J instructions.
    @(negedge clk);
    rst4 = 1'b0;
    mem_ready = 1'b0;
    #1;
    for (int i = 1; i <= 51; i++) begin
      apply(0, 6'd0);
      if (i == 47) check("wrap_cnt15", instr_count4, 15);
      if (i == 48) check("wrap_cnt0", instr_count4, 0);
      if (i == 51) begin
        check("wrap_cnt1", instr_count4, 1);
        check("wrap_fetch", {mr4, iord4}, 2'b10);
      end
    end

    @(negedge clk);
    rst = 1'b0;

    add(1, 6'd0,  E_FR,   0); add(1, 6'd0,  E_DEC,  0); add(0, 6'd0,  E_EXEC, 0); add(1, 6'd0, E_RWB, 0);
    add(1, 6'd43, E_FR,   1); add(1, 6'd43, E_DEC,  1); add(1, 6'd43, E_MADR, 1); add(1, 6'd43, E_MWR, 1);
    add(1, 6'd63, E_FR,   2); add(1, 6'd4,  E_DEC,  2); add(1, 6'd4,  E_BR,   2);
    add(1, 6'd2,  E_FR,   3); add(1, 6'd2,  E_DEC,  3); add(1, 6'd2,  E_JMP,  3);
    add(1, 6'd13, E_FR,   4); add(1, 6'd13, E_DEC,  4); add(1, 6'd13, E_OEX,  4); add(1, 6'd13, E_OWB, 4);
    foreach (tbl[i]) begin
      apply(tbl[i].mr, tbl[i].op);
      check($sformatf("tbl_ctl[%0d]", i), ctl, tbl[i].exp);
      check($sformatf("tbl_cnt[%0d]", i), instr_count, tbl[i].cnt);
    end

    // LW with 2 fetch waits and 3 read waits: 10 cycles.
    lw_mr = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    irw = 0;
    for (int i = 0; i < 10; i++) begin
      apply(lw_mr[i], 6'd35);
      irw += int'(IRWrite);
      if (i == 0) check("lw_start_cnt", instr_count, 5);
      if (!lw_mr[i]) check($sformatf("lw_wait_memread[%0d]", i), MemRead, 1);
      if (i >= 5 && i <= 8) check($sformatf("lw_wait_iord[%0d]", i), IorD, 1);
      if (i == 9) check("lw_memwb", ctl, E_MWB);
    end
    check("lw_irwrite_pulses", irw, 1);
    apply(1, 6'd35);
    check("lw_next_fetch", ctl, E_FR);
    check("lw_cnt", instr_count, 6);

    // Reset in the middle of a memory read.
    apply(1, 6'd35);
    apply(1, 6'd35);
    apply(0, 6'd35);
    check("pre_rst_memrd", ctl, E_MRD);
    rst = 1'b1;
    #1;
    check("midrst_ctl", ctl, 0);
    check("midrst_cnt", instr_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Illegal opcode.
    apply(1, 6'd63);
    check("rst_release_fetch", ctl, E_FR);
    check("rst_release_cnt", instr_count, 0);
    apply(1, 6'd63);
    check("ill_decode", ctl, E_DEC);
    apply(1, 6'd63);
    check("ill_ctl", ctl, 0);
`ifdef ILLEGAL_TRAP_EN
    check("ill_flag", illegal_op, 1);
    for (int i = 0; i < 12; i++) begin
      apply(1, 6'($urandom_range(0, 63)));
      check($sformatf("trap_ctl[%0d]", i), ctl, 0);
      check($sformatf("trap_flag[%0d]", i), illegal_op, 1);
    end
    check("trap_cnt_frozen", instr_count, 0);
    nops = 6;
`else
    check("ill_flag", illegal_op, 0);
    apply(0, 6'd0);
    check("ill_nop_fetch", ctl, E_FW);
    check("ill_nop_cnt", instr_count, 1);
    nops = 7;
`endif

    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random instruction stream against per-instruction aggregates.
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd13, 6'd63};
    exp_cnt = 0;
    ninstr = 0;
    budget = 0;
    seen = 1'b1;
    cur_op = 6'd0;
    cyc = 0; waits = 0; irw = 0; rw = 0; pcw = 0;
    while (ninstr <= 120 && budget < 20000) begin
      budget++;
      r = ($urandom_range(0, 3) != 0);
      apply(r, seen ? cur_op : 6'($urandom_range(0, 63)));
      if (MemRead && !IorD && seen) begin
        if (ninstr > 0) begin
          check($sformatf("rand_cycles op%0d", cur_op), cyc, base_cycles(cur_op) + waits);
          check($sformatf("rand_irwrite op%0d", cur_op), irw, 1);
          check($sformatf("rand_regwrite op%0d", cur_op), rw,
                (cur_op == 6'd0 || cur_op == 6'd35 || cur_op == 6'd13) ? 1 : 0);
          check($sformatf("rand_pcwrite op%0d", cur_op), pcw, (cur_op == 6'd2) ? 2 : 1);
          exp_cnt++;
        end
        check("rand_cnt", instr_count, exp_cnt);
        ninstr++;
        cur_op = ops[$urandom_range(0, nops - 1)];
        cyc = 0; waits = 0; irw = 0; rw = 0; pcw = 0;
        seen = 1'b0;
      end
      cyc++;
      if ((MemRead || MemWrite) && !r) waits++;
      if (IRWrite) begin
        irw++;
        seen = 1'b1;
      end
      rw += int'(RegWrite);
      pcw += int'(PCWrite);
      if (cyc > 60) begin
        check("rand_instr_timeout", cyc, 0);
        break;
      end
    end
    if (ninstr <= 120) check("rand_stream_incomplete", ninstr, 121);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
